// File: rtl/io_bus_master.sv
`timescale 1ns/1ps
// io_bus_master
// Initiator for the 16-bit enable/strobe/din/dout/wait IO bus. One request
// becomes one transaction: raise the selected channel enable, strobe the
// command word, strobe req_len data words, then drop the enable.
//
// Ports
//   clk, rst        system clock, synchronous active-high reset
//   req_*           request handshake. req_valid/req_ready: a request is taken
//                   on any rising edge where both are high. req_ready is high
//                   only while idle, so requests arriving while busy are ignored.
//   wr_data/wr_valid/wr_ready
//                   write word source. wr_ready is a one-cycle pulse in the
//                   same cycle as the data strobe that consumes wr_data.
//   rd_data/rd_valid
//                   io_dout captured at each data strobe; rd_valid pulses
//                   the cycle after the strobe.
//   done/err        done pulses at the end of every transaction; err pulses
//                   alongside it on timeout or a reserved channel select.
//   busy            high whenever not idle
//   io_uio/io_fpga/io_osd
//                   registered channel enables, at most one high
//   io_strobe/io_din
//                   word strobe and the word driven with it (0 otherwise)
//   io_wait/io_dout responder stall and read word
//   state_dbg       current FSM state
module io_bus_master #(
    parameter int SETUP   = 1,
    parameter int GAP     = 2,
    parameter int HOLD    = 1,
    parameter int TIMEOUT = 4095
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_sel,
    input  logic [15:0] req_cmd,
    input  logic [7:0]  req_len,
    input  logic        req_wr,
    input  logic [15:0] wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic [15:0] rd_data,
    output logic        rd_valid,
    output logic        done,
    output logic        err,
    output logic        busy,
    output logic        io_uio,
    output logic        io_fpga,
    output logic        io_osd,
    output logic        io_strobe,
    output logic [15:0] io_din,
    input  logic        io_wait,
    input  logic [15:0] io_dout,
    output logic [2:0]  state_dbg
);

    // One shared counter times SETUP, GAP and HOLD; size it for the largest.
    localparam int PMAX0 = (SETUP > GAP) ? SETUP : GAP;
    localparam int PMAX  = (PMAX0 > HOLD) ? PMAX0 : HOLD;
    localparam int CW    = $clog2(PMAX + 1);
    localparam int TW    = $clog2(TIMEOUT + 1);

    localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD - 1);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_CMD   = 3'd2,
        S_GAP   = 3'd3,
        S_DATA  = 3'd4,
        S_HOLD  = 3'd5
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [TW-1:0] tcnt;
    logic [15:0]   cmd_q;
    logic [7:0]    rem;
    logic          wr_q;
    logic [2:0]    en;     // {osd, fpga, uio}
    logic          cmd_fire;
    logic          data_fire;

    // The strobe has to land in the very cycle the responder stops stalling
    // (and, for writes, the cycle the host offers a word), so strobe, din and
    // wr_ready are decoded from the current state and inputs rather than
    // registered.
    assign cmd_fire  = (state == S_CMD) && !io_wait;
    assign data_fire = (state == S_DATA) && !io_wait && (!wr_q || wr_valid);

    assign io_strobe = cmd_fire || data_fire;
    assign io_din    = cmd_fire              ? cmd_q   :
                       (data_fire && wr_q)   ? wr_data : 16'h0000;
    assign wr_ready  = data_fire && wr_q;

    assign req_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign io_uio    = en[0];
    assign io_fpga   = en[1];
    assign io_osd    = en[2];
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            tcnt     <= '0;
            cmd_q    <= 16'h0000;
            rem      <= 8'd0;
            wr_q     <= 1'b0;
            en       <= 3'b000;
            done     <= 1'b0;
            err      <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= 16'h0000;
        end else begin
            done     <= 1'b0;
            err      <= 1'b0;
            rd_valid <= 1'b0;

            case (state)
                S_IDLE: begin
                    cnt  <= '0;
                    tcnt <= '0;
                    if (req_valid) begin
                        cmd_q <= req_cmd;
                        rem   <= req_len;
                        wr_q  <= req_wr;
                        if (req_sel == 2'd3) begin
                            // Reserved channel: finish immediately, never
                            // touch an enable.
                            done <= 1'b1;
                            err  <= 1'b1;
                        end else begin
                            en    <= 3'b001 << req_sel;
                            state <= S_SETUP;
                        end
                    end
                end

                S_SETUP: begin
                    if (cnt == SETUP_LAST) begin
                        cnt   <= '0;
                        state <= S_CMD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_CMD: begin
                    if (io_wait) begin
                        if (tcnt == TMO_LAST) begin
                            en    <= 3'b000;
                            done  <= 1'b1;
                            err   <= 1'b1;
                            tcnt  <= '0;
                            state <= S_IDLE;
                        end else begin
                            tcnt <= tcnt + 1'b1;
                        end
                    end else begin
                        // Command strobe; io_dout is not reported for it.
                        tcnt  <= '0;
                        cnt   <= '0;
                        state <= S_GAP;
                    end
                end

                S_GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt   <= '0;
                        state <= (rem != 8'd0) ? S_DATA : S_HOLD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_DATA: begin
                    if (io_wait) begin
                        if (tcnt == TMO_LAST) begin
                            en    <= 3'b000;
                            done  <= 1'b1;
                            err   <= 1'b1;
                            tcnt  <= '0;
                            state <= S_IDLE;
                        end else begin
                            tcnt <= tcnt + 1'b1;
                        end
                    end else begin
                        // A missing write word stalls here without timing
                        // out; only responder stalls count.
                        tcnt <= '0;
                        if (data_fire) begin
                            rd_data  <= io_dout;
                            rd_valid <= 1'b1;
                            rem      <= rem - 8'd1;
                            cnt      <= '0;
                            state    <= S_GAP;
                        end
                    end
                end

                S_HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        cnt   <= '0;
                        en    <= 3'b000;
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    en    <= 3'b000;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_io_bus_master.sv
`timescale 1ns/1ps
// Self-checking bench for io_bus_master.
module tb_io_bus_master;

    localparam int SETUP   = 1;
    localparam int GAP     = 1;
    localparam int HOLD    = 1;
    localparam int TIMEOUT = 8;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_sel;
    logic [15:0] req_cmd;
    logic [7:0]  req_len;
    logic        req_wr;
    logic [15:0] wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        done;
    logic        err;
    logic        busy;
    logic        io_uio;
    logic        io_fpga;
    logic        io_osd;
    logic        io_strobe;
    logic [15:0] io_din;
    logic        io_wait;
    logic [15:0] io_dout;
    logic [2:0]  state_dbg;

    io_bus_master #(
        .SETUP(SETUP), .GAP(GAP), .HOLD(HOLD), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_sel(req_sel),
        .req_cmd(req_cmd), .req_len(req_len), .req_wr(req_wr),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .done(done), .err(err), .busy(busy),
        .io_uio(io_uio), .io_fpga(io_fpga), .io_osd(io_osd),
        .io_strobe(io_strobe), .io_din(io_din),
        .io_wait(io_wait), .io_dout(io_dout),
        .state_dbg(state_dbg)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int n_cmp  = 0;
    int n_fail = 0;

    logic [15:0] exp_q[$];      // expected rd_data words, in strobe order
    logic [15:0] wr_words[$];   // write words offered to the DUT
    logic [15:0] rd_seen[$];    // rd_data values seen on rd_valid
    int          strobe_cyc[0:255];
    logic [15:0] strobe_din[0:255];
    int          n_strobe;
    int          n_wr_ready;
    int          done_at;
    logic        got_err;
    logic [2:0]  en_seen;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One transaction, driven and checked cycle by cycle against a rule-level
    // model: strobes may only occur from the earliest allowed cycle (SETUP
    // after accept, GAP after a strobe), must occur on the first cycle the
    // responder and the host allow it, done follows the last strobe after
    // GAP+HOLD, and TIMEOUT consecutive responder stalls abort.
    //   wait_mode: 0 never stall, 1 random short stalls, 2 stall forever,
    //              3 stall 5 cycles before data strobe 2
    //   wv_mode:   0 write word always valid, 1 random, 2 invalid for
    //              10 cycles before data strobe 1
    //   rst_after: strobe index after which reset is pulsed (-1 = never)
    task automatic run_txn(input logic [1:0] sel, input logic [15:0] cmd,
                           input logic [7:0] len, input logic wr,
                           input int wait_mode, input int wv_mode,
                           input bit dout_rand, input logic [15:0] dout_val,
                           input int rst_after);
        int         elig, idx, last, wrun, rst_at, rd_due, stall_w, stall_v;
        bit         tmo_pend, fin, in_elig, exp_fire, exp_done, exp_err;
        logic [2:0] exp_en;
        logic [15:0] exp_w;

        exp_en = (sel == 2'd0) ? 3'b001 : (sel == 2'd1) ? 3'b010 :
                 (sel == 2'd2) ? 3'b100 : 3'b000;
        exp_q.delete();
        rd_seen.delete();
        n_strobe   = 0;
        n_wr_ready = 0;
        done_at    = -1;
        got_err    = 1'b0;
        en_seen    = 3'b000;

        @(posedge clk); #1;
        req_valid = 1'b1; req_sel = sel; req_cmd = cmd; req_len = len; req_wr = wr;
        io_wait = 1'b0; wr_valid = 1'b0;
        @(negedge clk);
        check("req_ready_idle", req_ready, 1);
        check("enable_idle", {io_osd, io_fpga, io_uio}, 0);

        elig = SETUP + 1; idx = 0; last = -1000; wrun = 0; rst_at = -1;
        rd_due = -1; stall_w = 0; stall_v = 0; tmo_pend = 0; fin = 0;

        for (int c = 1; c <= 3000 && !fin; c++) begin
            @(posedge clk); #1;
            in_elig = (sel != 2'd3) && !tmo_pend && (c >= elig) && (idx <= int'(len));

            rst = (c == rst_at);
            // Junk requests while busy must be ignored; never on the cycle the
            // DUT is back in idle.
            if (sel != 2'd3 && !tmo_pend && rst_at < 0 &&
                !(idx == int'(len) + 1 && c >= last + GAP + HOLD + 1)) begin
                req_valid = 1'($urandom_range(0, 1));
            end else begin
                req_valid = 1'b0;
            end
            req_sel = 2'($urandom); req_cmd = 16'($urandom);
            req_len = 8'($urandom); req_wr = 1'($urandom);

            case (wait_mode)
                1: io_wait = in_elig ? (wrun < 5 && $urandom_range(0, 99) < 30)
                                     : 1'($urandom_range(0, 1));
                2: io_wait = 1'b1;
                3: begin
                    io_wait = (idx == 2 && in_elig && stall_w < 5);
                    if (io_wait) stall_w++;
                end
                default: io_wait = 1'b0;
            endcase
            case (wv_mode)
                1: wr_valid = ($urandom_range(0, 99) < 70);
                2: begin
                    wr_valid = !(idx == 1 && in_elig && stall_v < 10);
                    if (!wr_valid) stall_v++;
                end
                default: wr_valid = 1'b1;
            endcase
            wr_data = (wr_valid && wr_words.size() > 0) ? wr_words[0] : 16'($urandom);
            io_dout = dout_rand ? 16'($urandom) : dout_val;

            @(negedge clk);
            en_seen |= {io_osd, io_fpga, io_uio};
            if (wr_ready) n_wr_ready++;

            if (rst_at > 0 && c == rst_at + 1) begin
                check("rst_enable", {io_osd, io_fpga, io_uio}, 0);
                check("rst_done", done, 0);
                check("rst_err", err, 0);
                check("rst_busy", busy, 0);
                check("rst_req_ready", req_ready, 1);
                check("rst_strobe", io_strobe, 0);
                check("rst_din", io_din, 0);
                check("rst_rd_valid", rd_valid, 0);
                check("rst_rd_data", rd_data, 0);
                check("rst_wr_ready", wr_ready, 0);
                fin = 1;
            end else begin
                exp_done = tmo_pend || (sel == 2'd3 && c == 1) ||
                           (sel != 2'd3 && idx == int'(len) + 1 && c == last + GAP + HOLD + 1);
                exp_err  = tmo_pend || (sel == 2'd3);
                check("done", done, exp_done);
                check("err", err, exp_done && exp_err);
                if (exp_done) begin
                    check("enable_at_done", {io_osd, io_fpga, io_uio}, 0);
                    check("busy_at_done", busy, 0);
                    check("req_ready_at_done", req_ready, 1);
                    done_at = c;
                    got_err = err;
                    fin = 1;
                end else begin
                    check("enable", {io_osd, io_fpga, io_uio}, exp_en);
                    check("busy", busy, 1);
                    check("req_ready_busy", req_ready, 0);
                end

                check("rd_valid", rd_valid, c == rd_due);
                if (c == rd_due) begin
                    check("rd_data", rd_data, exp_q.pop_front());
                    rd_seen.push_back(rd_data);
                end

                exp_fire = in_elig && !io_wait && (idx == 0 || !wr || wr_valid);
                check("strobe", io_strobe, exp_fire);
                if (exp_fire) begin
                    if (idx == 0) begin
                        check("din_cmd", io_din, cmd);
                    end else begin
                        exp_w = wr ? wr_words.pop_front() : 16'h0000;
                        check("din_data", io_din, exp_w);
                        exp_q.push_back(io_dout);
                        rd_due = c + 1;
                    end
                    check("wr_ready", wr_ready, (idx > 0) && wr);
                    strobe_cyc[idx] = c;
                    strobe_din[idx] = io_din;
                    n_strobe++;
                    if (rst_after >= 0 && idx == rst_after) rst_at = c + 1;
                    idx++;
                    last = c;
                    elig = c + GAP + 1;
                end else begin
                    check("din_idle", io_din, 0);
                    check("wr_ready_idle", wr_ready, 0);
                end

                if (in_elig && io_wait) wrun++; else wrun = 0;
                if (wrun == TIMEOUT) tmo_pend = 1;
            end
        end
        if (!fin) begin
            n_cmp++; n_fail++;
            $display("FAIL txn_bound: got no end of transaction expected one within 3000 cycles");
        end
        req_valid = 1'b0;
        rst = 1'b0;
    endtask

    // ---------------- table ----------------
    typedef struct {
        logic [1:0]  sel;
        logic [15:0] cmd;
        logic [7:0]  len;
        logic        wr;
        int          exp_done;   // cycles from accept to done
        logic        exp_err;
        int          exp_nstb;
        logic [2:0]  exp_en;     // {osd, fpga, uio} seen during the transaction
    } vec_t;

    vec_t vecs[5];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected one by 2 ms");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{2'd0, 16'h0012, 8'd0, 1'b0, 5,  1'b0, 1, 3'b001};
        vecs[1] = '{2'd1, 16'h1234, 8'd3, 1'b1, 11, 1'b0, 4, 3'b010};
        vecs[2] = '{2'd2, 16'hBEEF, 8'd1, 1'b0, 7,  1'b0, 2, 3'b100};
        vecs[3] = '{2'd3, 16'h0000, 8'd5, 1'b1, 1,  1'b1, 0, 3'b000};
        vecs[4] = '{2'd0, 16'h0F0F, 8'd2, 1'b1, 9,  1'b0, 3, 3'b001};

        rst = 1'b1; req_valid = 1'b0; req_sel = 2'd0; req_cmd = 16'h0;
        req_len = 8'd0; req_wr = 1'b0; wr_data = 16'h0; wr_valid = 1'b0;
        io_wait = 1'b0; io_dout = 16'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_req_ready", req_ready, 1);
        check("reset_busy", busy, 0);
        check("reset_enable", {io_osd, io_fpga, io_uio}, 0);
        check("reset_done", done, 0);
        check("reset_err", err, 0);
        check("reset_strobe", io_strobe, 0);
        check("reset_din", io_din, 0);
        check("reset_rd_valid", rd_valid, 0);
        check("reset_rd_data", rd_data, 0);
        check("reset_wr_ready", wr_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Table vectors: quiet responder, write words always available.
        for (int v = 0; v < 5; v++) begin
            wr_words.delete();
            for (int i = 0; i < int'(vecs[v].len); i++) wr_words.push_back(16'hC000 + 16'(i));
            run_txn(vecs[v].sel, vecs[v].cmd, vecs[v].len, vecs[v].wr, 0, 0, 1'b0, 16'h1234, -1);
            check($sformatf("vec%0d_done_at", v), done_at, vecs[v].exp_done);
            check($sformatf("vec%0d_err", v), got_err, vecs[v].exp_err);
            check($sformatf("vec%0d_strobes", v), n_strobe, vecs[v].exp_nstb);
            check($sformatf("vec%0d_enable", v), en_seen, vecs[v].exp_en);
            if (vecs[v].exp_nstb > 0) check($sformatf("vec%0d_first_strobe", v), strobe_cyc[0], SETUP + 1);
        end

        // Write burst on FPGA channel with a fixed read word.
        wr_words.delete();
        wr_words.push_back(16'hA001); wr_words.push_back(16'hA002); wr_words.push_back(16'hA003);
        run_txn(2'd1, 16'h00C3, 8'd3, 1'b1, 0, 0, 1'b0, 16'h5A5A, -1);
        check("burst_din0", strobe_din[0], 16'h00C3);
        check("burst_din1", strobe_din[1], 16'hA001);
        check("burst_din2", strobe_din[2], 16'hA002);
        check("burst_din3", strobe_din[3], 16'hA003);
        check("burst_wr_ready_count", n_wr_ready, 3);
        check("burst_rd_count", rd_seen.size(), 3);
        for (int i = 0; i < rd_seen.size(); i++) check("burst_rd_word", rd_seen[i], 16'h5A5A);
        for (int k = 1; k < 4; k++) check("burst_spacing", strobe_cyc[k] - strobe_cyc[k-1] >= 2, 1);

        // Responder stalls 5 cycles before the second data strobe.
        wr_words.delete();
        run_txn(2'd2, 16'h0042, 8'd3, 1'b0, 3, 0, 1'b0, 16'h0777, -1);
        check("stall5_delay", strobe_cyc[2] - strobe_cyc[1], GAP + 1 + 5);
        check("stall5_err", got_err, 0);
        check("stall5_strobes", n_strobe, 4);

        // Responder stuck in wait: timeout abort.
        run_txn(2'd0, 16'h0099, 8'd2, 1'b0, 2, 0, 1'b0, 16'h0000, -1);
        check("timeout_done_at", done_at, SETUP + TIMEOUT + 1);
        check("timeout_err", got_err, 1);
        check("timeout_strobes", n_strobe, 0);

        // Host withholds the first write word, then reset lands in the gap.
        wr_words.delete();
        wr_words.push_back(16'hB001); wr_words.push_back(16'hB002); wr_words.push_back(16'hB003);
        run_txn(2'd1, 16'h0055, 8'd3, 1'b1, 0, 2, 1'b0, 16'h3C3C, 1);
        check("wv_stall_delay", strobe_cyc[1] - strobe_cyc[0], GAP + 1 + 10);
        check("rst_no_done", done_at, -1);
        check("rst_strobes", n_strobe, 2);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("post_rst_done", done, 0);
            check("post_rst_busy", busy, 0);
        end

        // Randomized transactions.
        for (int t = 0; t < 40; t++) begin
            logic [1:0] s;
            logic [7:0] l;
            logic       w;
            s = 2'($urandom_range(0, 2));
            if ($urandom_range(0, 9) == 0) s = 2'd3;
            l = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(10, 40)) : 8'($urandom_range(0, 5));
            w = 1'($urandom_range(0, 1));
            wr_words.delete();
            for (int i = 0; i < int'(l); i++) wr_words.push_back(16'($urandom));
            run_txn(s, 16'($urandom), l, w, 1, 1, 1'b1, 16'h0000, -1);
            check("rand_err", got_err, s == 2'd3);
            check("rand_strobes", n_strobe, (s == 2'd3) ? 0 : int'(l) + 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/io_bus_master.md
Name: io_bus_master

Overview:
- Initiator for the 16-bit HPS-style IO bus (enable / strobe / din / dout / wait) that user_io and the minimig OSD/FPGA channels respond on.
- Executes one transaction per request: assert one channel enable, strobe a command word, strobe N data words, then release the enable.
- Used as an on-FPGA boot/config sequencer and as the bus driver in the system testbench, so responder blocks can be exercised without the HPS.

Parameters:
- SETUP, 1, idle cycles between enable assertion and the command strobe (min 1).
- GAP, 2, minimum idle cycles between consecutive strobes (min 1).
- HOLD, 1, cycles after the last strobe before the enable drops (min 1).
- TIMEOUT, 4095, consecutive io_wait-high cycles before abort (min 1).

Ports:
- clk  in  1  system clock (clk_28 domain)
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  transaction request
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid & req_ready
- req_sel  in  2  channel select: 0 = UIO, 1 = FPGA, 2 = OSD, 3 = reserved (rejected)
- req_cmd  in  16  command word
- req_len  in  8  number of data words, 0..255
- req_wr  in  1  1 = data words come from wr_data; 0 = drive zeros
- wr_data  in  16  write word
- wr_valid  in  1  write word available
- wr_ready  out  1  1-cycle pulse that consumes the current write word
- rd_data  out  16  word sampled from io_dout
- rd_valid  out  1  1-cycle pulse per data strobe
- done  out  1  1-cycle pulse at end of transaction
- err  out  1  1-cycle pulse together with done on abort or reserved select
- busy  out  1  high when not in IDLE
- io_uio / io_fpga / io_osd  out  1 each  channel enables, at most one high
- io_strobe  out  1  single-cycle word strobe
- io_din  out  16  word driven to the responder
- io_wait  in  1  responder stall
- io_dout  in  16  responder read word

Behaviour:
- Reset: state IDLE; all outputs 0 except req_ready = 1. rst mid-transaction drops the enable in the same edge, emits no done, and discards the latched request.
- Accept: latch sel/cmd/len/wr.
  - sel = 3: go to IDLE next cycle, pulse done + err, drive no enable.
  - Otherwise assert the selected enable registered on the next cycle and go to SETUP.
- SETUP: count SETUP cycles, then go to CMD.
- CMD: wait while io_wait = 1. When io_wait = 0, issue io_strobe = 1 with io_din = cmd for exactly one cycle.
- GAP: hold io_strobe = 0 for at least GAP cycles.
  - If remaining words > 0, go to DATA; else go to HOLD.
- DATA: a strobe fires in the first cycle where io_wait = 0 and (!wr or wr_valid).
  - In that cycle: io_din = wr ? wr_data : 0; wr_ready = wr (same cycle); rd_data <= io_dout captured at that edge; rd_valid pulses the next cycle.
  - Decrement the remaining count, then go to GAP.
  - io_dout during the command strobe is not reported.
- HOLD: count HOLD cycles with the enable still high; then drop the enable, pulse done, and return to IDLE.
  - The enable stays low for at least 1 cycle before the next request can assert any enable.
- io_din is 0 whenever io_strobe = 0.
- Timeout counter (width clog2(TIMEOUT+1)):
  - Increments in CMD/DATA while io_wait = 1; clears on any cycle with io_wait = 0 or on a strobe.
  - On reaching TIMEOUT: drop the enable next cycle, pulse done + err, return to IDLE.
- wr_valid low in DATA stalls indefinitely with no timeout; the host is responsible for supplying data.
- req_len = 0: command strobe only, then GAP, then HOLD.
- A new req_valid during busy is ignored; req_ready = 0.

Test Plan:
- sel = 0, cmd = 0x0012, len = 0, io_wait = 0, SETUP = GAP = HOLD = 1 -> io_uio high 1 cycle after accept; strobe with din = 0x0012 after 1 setup cycle; done 1+1 cycles later; io_uio low the cycle done pulses.
- sel = 1, len = 3, wr = 1, wr_data 0xA001/0xA002/0xA003 always valid, io_dout = 0x5A5A -> 4 strobes spaced ≥ 2 cycles; din sequence 0x????cmd, A001, A002, A003; three wr_ready pulses; three rd_valid pulses with 0x5A5A.
- io_wait high for 5 cycles before the second data strobe -> no strobe while waiting; strobe on the first cycle io_wait = 0; no err.
- TIMEOUT = 8, io_wait stuck high after accept -> after 8 wait cycles the enable drops, done + err pulse, busy = 0, req_ready = 1.
- wr = 1, wr_valid low 10 cycles in DATA -> no strobe, no timeout; strobe the cycle wr_valid rises; then rst asserted mid-GAP -> all outputs 0 the next cycle, no done.
- sel = 3 -> no enable ever asserted; done + err one cycle after accept.
